fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 8-bit single-issue core. Owns the program counter, drives the combinational instruction memory's read address, and registers each fetched 8-bit instruction with its PC into the IF/ID pipeline register for the decoder. Jumps (opcode 2'b11) are resolved and folded here, so the decoder only ever receives ALU and memory instructions.

## Interface
Parameters:
- PC_W, 8, program counter and IMEM address width
- PROG_LEN, 32, number of valid IMEM words; fetch at PC >= PROG_LEN ends the program

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from PC 0; honoured only in IDLE or DONE
- stall  in  1  downstream hazard; freezes PC, state and IF/ID register
- imem_addr  out  PC_W  read address to instruction memory (equals pc register)
- imem_instr  in  8  instruction returned combinationally for imem_addr
- if_valid  out  1  if_instr/if_pc hold a real instruction
- if_instr  out  8  registered instruction
- if_pc  out  PC_W  PC of if_instr
- done  out  1  high in DONE state
- fetch_cnt  out  8  issued-instruction counter (only with IF_PERF_CNT_EN)

## Operation
- Instruction fields: [7:6] opcode (00 add, 01 lw, 10 sw, 11 j), [5:4] rs, [3:2] rt, [1:0] rd/imm.
- States: IDLE, RUN, DONE. Reset -> IDLE; pc=0, if_valid=0, if_instr=0, if_pc=0, done=0, fetch_cnt=0.
- IDLE: start -> RUN (pc=0). Otherwise hold.
- RUN, stall=1: hold all registers and state; if_valid keeps its value.
- RUN, stall=0, pc >= PROG_LEN: -> DONE, if_valid<=0.
- RUN, stall=0, opcode != 11: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1.
- RUN, stall=0, opcode == 11: if_valid<=0 (bubble), pc<=pc+1+sext(imem_instr[5:0]).
- DONE: done=1, if_valid=0; start -> RUN with pc=0, done cleared.
- PC arithmetic modulo 2^PC_W; wrap-around is legal and then caught by the PROG_LEN check.
- start during RUN ignored. stall in IDLE/DONE has no effect.
- Reset mid-run: immediate return to IDLE, in-flight instruction discarded.

## Timing
- imem_addr is purely the pc register; IMEM is combinational, fetch completes in the same cycle.
- start sampled at edge N -> RUN; first instruction visible on if_* after edge N+1.
- Throughput one instruction per unstalled cycle; each taken jump costs exactly one bubble.
- done rises on the edge that detects pc >= PROG_LEN.

## Configuration
- IF_PERF_CNT_EN defined: fetch_cnt increments on every edge that sets if_valid<=1 with stall=0, saturates at 255, cleared by reset and by start.
- Not defined: fetch_cnt port present, tied to 0; no counter flops.

## Structure
- Package cpu_pkg: opcode constants OP_ADD, OP_LW, OP_SW, OP_J; field-position constants; fetch state enum.
- Sub-module next_pc_calc: combinational next-PC (pc+1 or jump target) and is_jump flag.

## Test plan
- Reset, start, PROG_LEN=6, program 0x49,0xC1,0x00,0xA9,0x7D,0x1C -> if_* sequence (0x49,pc0), bubble, (0xA9,pc3), (0x7D,pc4), (0x1C,pc5); done after pc=6.
- Stall held 3 cycles while (0xA9,pc3) valid -> if_* and imem_addr=3 unchanged, then resume with 0x7D.
- Jump 0xFF at pc 2 (offset -1) -> next pc 2 (self loop), if_valid stays 0 each cycle.
- Reset asserted mid-run at pc 4 -> outputs zero asynchronously, state IDLE, start restarts at pc 0.
- start during DONE -> re-fetches 0x49 at pc 0; with IF_PERF_CNT_EN fetch_cnt=4 after first run, 0 after restart.
- PROG_LEN=256, jump wrapping pc 250 to 5 -> fetch continues at pc 5.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode and field constants plus the fetch state type for the 8-bit core
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 6;
  localparam int RS_HI   = 5;
  localparam int RS_LO   = 4;
  localparam int RT_HI   = 3;
  localparam int RT_LO   = 2;
  localparam int RD_HI   = 1;
  localparam int RD_LO   = 0;
  localparam int JOFF_HI = 5;
  localparam int JOFF_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - sequential or jump-target next PC for the instruction at pc
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  output logic [PC_W-1:0] next_pc,
  output logic            is_jump
);

  logic [PC_W-1:0] offset;

  // Jump offset is relative to pc+1 and sign-extended; PC_W must exceed JOFF_W.
  always_comb begin
    is_jump = (instr[OPC_HI:OPC_LO] == OP_J);
    offset  = is_jump ? {{(PC_W-JOFF_W){instr[JOFF_HI]}}, instr[JOFF_HI:0]} : '0;
    next_pc = pc + PC_W'(1) + offset;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, IMEM addressing, jump folding and IF/ID register
// Optional issue counter on fetch_cnt enabled by IF_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_instr,
  output logic            if_valid,
  output logic [7:0]      if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            done,
  output logic [7:0]      fetch_cnt
);

  localparam int unsigned PROG_END = PROG_LEN;

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n, if_pc_n, next_pc;
  logic [7:0]      if_instr_n;
  logic            if_valid_n, is_jump, pc_end, issue, restart;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc      (pc),
    .instr   (imem_instr),
    .next_pc (next_pc),
    .is_jump (is_jump)
  );

  assign pc_end    = 32'(pc) >= PROG_END;
  assign imem_addr = pc;
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      if_valid <= if_valid_n;
      if_instr <= if_instr_n;
      if_pc    <= if_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc_n    = if_pc;
    issue      = 1'b0;
    restart    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if_valid_n = 1'b0;
        if (start) begin
          state_n = ST_RUN;
          pc_n    = '0;
          restart = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (pc_end) begin
            state_n    = ST_DONE;
            if_valid_n = 1'b0;
          end else if (is_jump) begin
            // Jumps never reach the decoder: one bubble, redirect pc.
            if_valid_n = 1'b0;
            pc_n       = next_pc;
          end else begin
            if_valid_n = 1'b1;
            if_instr_n = imem_instr;
            if_pc_n    = pc;
            pc_n       = next_pc;
            issue      = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (restart)
      cnt <= '0;
    else if (issue && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  assign fetch_cnt = cnt;
`else
  logic unused_perf;

  assign unused_perf = issue ^ restart;
  assign fetch_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a program-level reference model
module tb_fetch_stage;

  localparam int PLEN = 6;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [7:0] imem_addr, imem_instr, if_instr, if_pc, fetch_cnt;
  logic       if_valid, done;

  logic       start_w = 1'b0;
  logic [7:0] w_addr, w_instr, w_if_instr, w_if_pc, w_cnt;
  logic       w_valid, w_done;

  logic [7:0]  mem  [0:255];
  logic [7:0]  mem2 [0:255];
  logic [15:0] exp_q[$];
  logic [15:0] model_q[$];
  int          model_steps;
  int          n_cmp = 0, n_bad = 0;
  logic        last_stall = 1'b0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];
  assign w_instr    = mem2[w_addr];

  fetch_stage #(.PC_W(8), .PROG_LEN(PLEN)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .done(done), .fetch_cnt(fetch_cnt)
  );

  fetch_stage #(.PC_W(8), .PROG_LEN(256)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w), .stall(1'b0),
    .imem_addr(w_addr), .imem_instr(w_instr),
    .if_valid(w_valid), .if_instr(w_if_instr), .if_pc(w_if_pc),
    .done(w_done), .fetch_cnt(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int n);
`ifdef IF_PERF_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return (n < 0) ? 8'd1 : 8'd0;
`endif
  endfunction

  // Program-level model: walk the program, skip jumps, list issued (pc, instr).
  function automatic bit model();
    int pc, steps, off;
    logic [7:0] ins;
    model_q.delete();
    pc = 0;
    steps = 0;
    while (pc < PLEN) begin
      if (steps >= 100) return 1'b0;
      ins = mem[pc];
      steps++;
      if (ins[7:6] == 2'b11) begin
        off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        pc  = (pc + 1 + off + 256) % 256;
      end else begin
        model_q.push_back({8'(pc), ins});
        pc++;
      end
    end
    model_steps = steps;
    return 1'b1;
  endfunction

  always @(posedge clk) last_stall <= stall;

  // Monitor: every fresh valid on the IF/ID register must match the next expected issue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset && if_valid && !last_stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got pc %0h instr %0h expected none", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", if_pc, e[15:8]);
        check("issue_instr", if_instr, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog(input int stall_pct);
    int n, cyc;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    start = 1'b1;
    stall = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (!done && cyc < 500) begin
      stall = (int'($urandom_range(0, 99)) < stall_pct);
      start = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      if (!stall) n++;
      #1;
      cyc++;
    end
    start = 1'b0;
    stall = 1'b0;
    check("run_done", done, 1);
    check("run_edges", n, model_steps + 1);
    check("run_drained", exp_q.size(), 0);
    check("run_fetch_cnt", fetch_cnt, cnt_exp(model_q.size()));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = (i == 250) ? 8'hCA : 8'(i % 64);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", imem_addr, 0);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_done", done, 0);
    check("rst_cnt", fetch_cnt, 0);
    reset = 1'b0;
    tick();

    // Directed program with a 3-cycle stall on (0xA9, pc3).
    mem[0] = 8'h49; mem[1] = 8'hC1; mem[2] = 8'h00;
    mem[3] = 8'hA9; mem[4] = 8'h7D; mem[5] = 8'h1C;
    void'(model());
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_addr", imem_addr, 0);
    tick();
    check("first_valid", if_valid, 1);
    check("first_instr", if_instr, 8'h49);
    check("first_pc", if_pc, 0);
    tick();
    check("bubble_valid", if_valid, 0);
    check("bubble_addr", imem_addr, 3);
    tick();
    check("a9_pc", if_pc, 3);
    stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_valid", if_valid, 1);
      check("stall_instr", if_instr, 8'hA9);
      check("stall_pc", if_pc, 3);
      check("stall_addr", imem_addr, 4);
    end
    stall = 1'b0;
    tick();
    check("resume_instr", if_instr, 8'h7D);
    check("resume_pc", if_pc, 4);
    for (int k = 0; k < 5 && !done; k++) tick();
    check("dir_done", done, 1);
    check("dir_done_valid", if_valid, 0);
    check("dir_drained", exp_q.size(), 0);
    check("dir_cnt", fetch_cnt, cnt_exp(4));

    // Restart from DONE, then asynchronous reset at pc 4.
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_cnt", fetch_cnt, 0);
    check("restart_addr", imem_addr, 0);
    tick();
    check("restart_instr", if_instr, 8'h49);
    tick();
    tick();
    check("pre_reset_addr", imem_addr, 4);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", if_valid, 0);
    check("arst_instr", if_instr, 0);
    check("arst_pc", if_pc, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_done", done, 0);
    check("arst_cnt", fetch_cnt, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    void'(model());
    run_prog(0);

    // Self-looping jump at pc 2.
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hFF;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    repeat (4) begin
      tick();
      check("loop_valid", if_valid, 0);
      check("loop_addr", imem_addr, 2);
      check("loop_done", done, 0);
    end
    check("loop_drained", exp_q.size(), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Random programs with random stalls and stray start pulses.
    for (int r = 0; r < 25; r++) begin
      do begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      end while (!model());
      run_prog(30);
    end

    // PROG_LEN=256 instance: jump at pc 250 wraps to pc 5.
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    check("wrap_pre_valid", w_valid, 1);
    check("wrap_pre_pc", w_if_pc, 249);
    check("wrap_pre_addr", w_addr, 250);
    tick();
    check("wrap_bubble", w_valid, 0);
    check("wrap_addr", w_addr, 5);
    tick();
    check("wrap_valid", w_valid, 1);
    check("wrap_pc", w_if_pc, 5);
    check("wrap_instr", w_if_instr, 8'h05);
    repeat (8) @(posedge clk);
    #1;
    check("wrap_cnt_sat", w_cnt, cnt_exp(259));
    check("wrap_done", w_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
